// File: rtl/resource_arbiter_if.sv
`timescale 1ns/1ps
// Bundle of request, resource and response signals between the requester lanes,
// the shared resource and the round-robin arbiter.
interface resource_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32
);
  logic                      flush;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        grant;
  logic [DATA_W-1:0]         res_in;
  logic                      res_in_valid;
  logic [DATA_W-1:0]         res_out;
  logic                      res_out_valid;
  logic [DATA_W-1:0]         resp_data;
  logic [NUM_REQ-1:0]        resp_valid;
  logic                      busy;
  logic                      timeout_err;

  // Environment side: lanes plus resource
  modport master (
    output flush, req, req_data, res_out, res_out_valid,
    input  grant, res_in, res_in_valid, resp_data, resp_valid, busy, timeout_err
  );

  // Arbiter side
  modport slave (
    input  flush, req, req_data, res_out, res_out_valid,
    output grant, res_in, res_in_valid, resp_data, resp_valid, busy, timeout_err
  );
endinterface

// File: rtl/resource_arbiter.sv
`timescale 1ns/1ps
// Round-robin arbiter: grants one lane at a time to a shared resource, issues its
// operand, and returns the result (or aborts on timeout/flush) to that lane.
module resource_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  resource_arbiter_if.slave bus
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [NUM_REQ-1:0] LANE0_ONEHOT = NUM_REQ'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t             state_reg;
  logic [PTR_W-1:0]   last_ptr_reg;
  logic [PTR_W-1:0]   win_reg;
  logic [TMR_W-1:0]   timer_reg;
  logic [NUM_REQ-1:0] grant_reg;
  logic [NUM_REQ-1:0] resp_valid_reg;
  logic [DATA_W-1:0]  res_in_reg;
  logic [DATA_W-1:0]  resp_data_reg;
  logic               res_in_valid_reg;
  logic               busy_reg;
  logic               timeout_err_reg;

  logic [DATA_W-1:0]  lane_data [NUM_REQ];
  logic [PTR_W-1:0]   cand_idx  [NUM_REQ];
  logic [NUM_REQ-1:0] cand_req;
  logic               arb_found;
  logic [PTR_W-1:0]   arb_win;

  // Candidate gi is the lane gi+1 positions after the last winner, wrapped.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
    logic [PTR_W:0] cand_sum;

    assign lane_data[gi] = bus.req_data[gi*DATA_W +: DATA_W];
    assign cand_sum      = {1'b0, last_ptr_reg} + (PTR_W+1)'(gi + 1);
    assign cand_idx[gi]  = (cand_sum >= (PTR_W+1)'(NUM_REQ))
                           ? PTR_W'(cand_sum - (PTR_W+1)'(NUM_REQ))
                           : PTR_W'(cand_sum);
    assign cand_req[gi]  = bus.req[cand_idx[gi]];
  end

  always_comb begin
    arb_found = 1'b0;
    arb_win   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!arb_found && cand_req[k]) begin
        arb_found = 1'b1;
        arb_win   = cand_idx[k];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg        <= IDLE;
      last_ptr_reg     <= PTR_W'(NUM_REQ - 1);
      win_reg          <= '0;
      timer_reg        <= '0;
      grant_reg        <= '0;
      resp_valid_reg   <= '0;
      res_in_reg       <= '0;
      resp_data_reg    <= '0;
      res_in_valid_reg <= 1'b0;
      busy_reg         <= 1'b0;
      timeout_err_reg  <= 1'b0;
    end else begin
      res_in_valid_reg <= 1'b0;
      resp_valid_reg   <= '0;
      timeout_err_reg  <= 1'b0;

      // Flush beats arbitration, the response and the timeout; pointer is kept.
      if (bus.flush) begin
        state_reg <= IDLE;
        grant_reg <= '0;
        timer_reg <= '0;
        busy_reg  <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (arb_found) begin
              win_reg          <= arb_win;
              grant_reg        <= LANE0_ONEHOT << arb_win;
              res_in_reg       <= lane_data[arb_win];
              res_in_valid_reg <= 1'b1;
              busy_reg         <= 1'b1;
              state_reg        <= ISSUE;
            end
          end
          ISSUE: begin
            timer_reg <= '0;
            state_reg <= WAIT;
          end
          WAIT: begin
            if (bus.res_out_valid) begin
              resp_data_reg  <= bus.res_out;
              resp_valid_reg <= grant_reg;
              grant_reg      <= '0;
              last_ptr_reg   <= win_reg;
              timer_reg      <= '0;
              busy_reg       <= 1'b0;
              state_reg      <= IDLE;
            end else if (timer_reg == TMR_W'(TIMEOUT - 1)) begin
              timeout_err_reg <= 1'b1;
              grant_reg       <= '0;
              last_ptr_reg    <= win_reg;
              timer_reg       <= '0;
              busy_reg        <= 1'b0;
              state_reg       <= IDLE;
            end else begin
              timer_reg <= timer_reg + TMR_W'(1);
            end
          end
          default: begin
            state_reg <= IDLE;
            grant_reg <= '0;
            busy_reg  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.grant        = grant_reg;
  assign bus.res_in       = res_in_reg;
  assign bus.res_in_valid = res_in_valid_reg;
  assign bus.resp_data    = resp_data_reg;
  assign bus.resp_valid   = resp_valid_reg;
  assign bus.busy         = busy_reg;
  assign bus.timeout_err  = timeout_err_reg;

endmodule

// File: tb/tb_resource_arbiter.sv
`timescale 1ns/1ps
// Self-checking bench for resource_arbiter: directed vector table, hand-written
// flush/reset sequences, and random transactions against a transaction-level model.
module tb_resource_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 16;

  localparam int OUT_RESP    = 0;
  localparam int OUT_TIMEOUT = 1;
  localparam int OUT_FLUSH   = 2;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  int   txn_id = 0;

  resource_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();

  resource_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NUM_REQ-1:0] grant;
    logic [DATA_W-1:0]  res_in;
    logic               issue_strobe;
    logic               busy;
    logic               strobe_after;
    logic               held_ok;
    int                 wait_n;
    logic [NUM_REQ-1:0] end_grant;
    logic [NUM_REQ-1:0] end_resp_valid;
    logic               end_err;
    logic [DATA_W-1:0]  end_resp_data;
    logic               end_busy;
  } obs_t;

  typedef struct {
    logic [NUM_REQ-1:0] req;
    int                 lat;       // WAIT cycle index carrying res_out_valid, -1 = never
    int                 flush_at;  // WAIT cycle index carrying flush, -1 = never
    logic [DATA_W-1:0]  rdat;
    int                 lane;
    int                 outcome;
    int                 wait_n;
  } vec_t;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL txn%0d %s: got %0h expected %0h", txn_id, name, act, exp);
    end
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input int lane);
    logic [NUM_REQ-1:0] v;
    v = '0;
    v[lane] = 1'b1;
    return v;
  endfunction

  // Round robin: first requesting lane after the last winner, wrapping.
  function automatic int model_pick(input logic [NUM_REQ-1:0] r, input int last);
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (r[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
    end
    return 0;
  endfunction

  // WAIT cycle on which the transaction ends: earliest of flush, response, timeout.
  function automatic int model_end(input int lat, input int fa);
    int e;
    e = TIMEOUT - 1;
    if (lat >= 0 && lat < e) e = lat;
    if (fa >= 0 && fa <= e) e = fa;
    return e;
  endfunction

  function automatic int model_outcome(input int lat, input int fa, input int e);
    if (fa == e) return OUT_FLUSH;
    if (lat == e) return OUT_RESP;
    return OUT_TIMEOUT;
  endfunction

  function automatic string oname(input int oc);
    case (oc)
      OUT_RESP:    return "resp";
      OUT_TIMEOUT: return "timeout";
      default:     return "flush";
    endcase
  endfunction

  // Called #1 after an edge with the arbiter idle; returns #1 after the ending edge.
  task automatic run_txn(input logic [NUM_REQ-1:0] rq, input logic [NUM_REQ*DATA_W-1:0] rd,
                         input int lat, input int fa, input logic [DATA_W-1:0] rdat,
                         output obs_t o);
    bus.req           = rq;
    bus.req_data      = rd;
    bus.flush         = 1'b0;
    bus.res_out_valid = 1'b0;
    @(posedge clk); #1;
    o.grant        = bus.grant;
    o.res_in       = bus.res_in;
    o.issue_strobe = bus.res_in_valid;
    o.busy         = bus.busy;
    // ISSUE cycle: a result strobe and request changes here must be ignored
    bus.req           = NUM_REQ'($urandom);
    bus.res_out_valid = 1'b1;
    bus.res_out       = $urandom;
    @(posedge clk); #1;
    o.strobe_after = bus.res_in_valid;
    o.held_ok      = 1'b1;
    o.wait_n       = -1;
    o.end_grant      = bus.grant;
    o.end_resp_valid = bus.resp_valid;
    o.end_err        = bus.timeout_err;
    o.end_resp_data  = bus.resp_data;
    o.end_busy       = bus.busy;
    for (int t = 0; t < TIMEOUT + 3; t++) begin
      bus.flush         = (t == fa);
      bus.res_out_valid = (t == lat);
      bus.res_out       = (t == lat) ? rdat : DATA_W'($urandom);
      bus.req           = NUM_REQ'($urandom);
      @(posedge clk); #1;
      bus.flush         = 1'b0;
      bus.res_out_valid = 1'b0;
      if (bus.grant == '0) begin
        o.wait_n         = t;
        o.end_grant      = bus.grant;
        o.end_resp_valid = bus.resp_valid;
        o.end_err        = bus.timeout_err;
        o.end_resp_data  = bus.resp_data;
        o.end_busy       = bus.busy;
        break;
      end
      if (bus.grant !== o.grant || bus.resp_valid !== '0 || bus.timeout_err !== 1'b0 ||
          bus.res_in !== o.res_in || bus.res_in_valid !== 1'b0)
        o.held_ok = 1'b0;
    end
    bus.req = '0;
  endtask

  task automatic compare_txn(input obs_t o, input logic [NUM_REQ-1:0] rq, input int lane,
                             input int oc, input int wn, input logic [DATA_W-1:0] exp_res_in,
                             input logic [DATA_W-1:0] exp_rd);
    logic [NUM_REQ-1:0] oh;
    oh = onehot(lane);
    check("grant",        64'(o.grant), 64'(oh));
    check("res_in",       64'(o.res_in), 64'(exp_res_in));
    check("issue_strobe", 64'(o.issue_strobe), 64'(1));
    check("busy_issue",   64'(o.busy), 64'(1));
    check("strobe_drop",  64'(o.strobe_after), 64'(0));
    check("held_in_wait", 64'(o.held_ok), 64'(1));
    check("wait_cycles",  64'(o.wait_n), 64'(wn));
    check("end_grant",    64'(o.end_grant), 64'(0));
    check("resp_valid",   64'(o.end_resp_valid), 64'((oc == OUT_RESP) ? oh : '0));
    check("timeout_err",  64'(o.end_err), 64'(oc == OUT_TIMEOUT));
    check("resp_data",    64'(o.end_resp_data), 64'(exp_rd));
    check("busy_end",     64'(o.end_busy), 64'(0));
    $display("txn %0d: req=%b lane=%0d outcome=%s wait=%0d grant=%b resp_valid=%b err=%0d",
             txn_id, rq, lane, oname(oc), wn, o.grant, o.end_resp_valid, o.end_err);
    txn_id++;
  endtask

  // Idle cycles with a stray result strobe, which must be dropped.
  task automatic idle_cycles(input int n, input logic [DATA_W-1:0] exp_rd);
    for (int i = 0; i < n; i++) begin
      bus.req           = '0;
      bus.res_out_valid = 1'b1;
      bus.res_out       = $urandom;
      @(posedge clk); #1;
      check("idle_grant",      64'(bus.grant), 64'(0));
      check("idle_resp_valid", 64'(bus.resp_valid), 64'(0));
      check("idle_resp_data",  64'(bus.resp_data), 64'(exp_rd));
      check("idle_busy",       64'(bus.busy), 64'(0));
      check("idle_timeout",    64'(bus.timeout_err), 64'(0));
    end
    bus.res_out_valid = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

  initial begin
    logic [DATA_W-1:0]         lane_words [NUM_REQ];
    logic [NUM_REQ*DATA_W-1:0] tbl_data;
    logic [DATA_W-1:0]         tbl_last_rd;
    vec_t                      vecs [13];
    obs_t                      o;
    int                        model_last;
    logic [DATA_W-1:0]         model_resp;

    lane_words = '{32'h1111_0000, 32'h2222_0001, 32'h3333_0002, 32'h4444_0003};
    for (int i = 0; i < NUM_REQ; i++) tbl_data[i*DATA_W +: DATA_W] = lane_words[i];

    vecs[0]  = '{4'b1111,  0, -1, 32'h0000_0A00, 0, OUT_RESP,    0};
    vecs[1]  = '{4'b1111,  0, -1, 32'h0000_0A01, 1, OUT_RESP,    0};
    vecs[2]  = '{4'b1111,  0, -1, 32'h0000_0A02, 2, OUT_RESP,    0};
    vecs[3]  = '{4'b1111,  0, -1, 32'h0000_0A03, 3, OUT_RESP,    0};
    vecs[4]  = '{4'b1111,  0, -1, 32'h0000_0A04, 0, OUT_RESP,    0};
    vecs[5]  = '{4'b0100,  2, -1, 32'hCAFE_0001, 2, OUT_RESP,    2};
    vecs[6]  = '{4'b1111, -1, -1, 32'h0000_0B06, 3, OUT_TIMEOUT, 15};
    vecs[7]  = '{4'b1111,  0, -1, 32'h0000_0B07, 0, OUT_RESP,    0};
    vecs[8]  = '{4'b1000, 15, -1, 32'h0000_0B08, 3, OUT_RESP,    15};
    vecs[9]  = '{4'b0010, -1,  4, 32'h0000_0B09, 1, OUT_FLUSH,   4};
    vecs[10] = '{4'b0110,  1, -1, 32'h0000_0B0A, 1, OUT_RESP,    1};
    vecs[11] = '{4'b1010,  0,  0, 32'h0000_0B0B, 3, OUT_FLUSH,   0};
    vecs[12] = '{4'b1010,  3, -1, 32'h0000_0B0C, 3, OUT_RESP,    3};

    reset             = 1'b1;
    bus.flush         = 1'b0;
    bus.req           = '0;
    bus.req_data      = '0;
    bus.res_out       = '0;
    bus.res_out_valid = 1'b0;
    @(posedge clk); #1;
    check("rst_grant",        64'(bus.grant), 64'(0));
    check("rst_res_in",       64'(bus.res_in), 64'(0));
    check("rst_res_in_valid", 64'(bus.res_in_valid), 64'(0));
    check("rst_resp_data",    64'(bus.resp_data), 64'(0));
    check("rst_resp_valid",   64'(bus.resp_valid), 64'(0));
    check("rst_busy",         64'(bus.busy), 64'(0));
    check("rst_timeout",      64'(bus.timeout_err), 64'(0));
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;

    // Directed vector table
    tbl_last_rd = '0;
    for (int v = 0; v < 13; v++) begin
      run_txn(vecs[v].req, tbl_data, vecs[v].lat, vecs[v].flush_at, vecs[v].rdat, o);
      if (vecs[v].outcome == OUT_RESP) tbl_last_rd = vecs[v].rdat;
      compare_txn(o, vecs[v].req, vecs[v].lane, vecs[v].outcome, vecs[v].wait_n,
                  lane_words[vecs[v].lane], tbl_last_rd);
      if (v == 9) idle_cycles(3, tbl_last_rd);
    end

    // Flush while idle blocks arbitration; res_in holds the last issued operand
    bus.req   = 4'b0001;
    bus.flush = 1'b1;
    @(posedge clk); #1;
    check("idle_flush_grant", 64'(bus.grant), 64'(0));
    check("idle_flush_busy",  64'(bus.busy), 64'(0));
    check("idle_flush_riv",   64'(bus.res_in_valid), 64'(0));
    check("res_in_hold",      64'(bus.res_in), 64'(lane_words[3]));
    bus.req   = '0;
    bus.flush = 1'b0;
    @(posedge clk); #1;

    // Asynchronous reset in the middle of WAIT
    bus.req = 4'b0100;
    @(posedge clk); #1;
    bus.req = '0;
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    check("async_rst_grant",     64'(bus.grant), 64'(0));
    check("async_rst_busy",      64'(bus.busy), 64'(0));
    check("async_rst_res_in",    64'(bus.res_in), 64'(0));
    check("async_rst_resp_data", 64'(bus.resp_data), 64'(0));
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check("no_replay_grant", 64'(bus.grant), 64'(0));
    check("no_replay_riv",   64'(bus.res_in_valid), 64'(0));
    run_txn(4'b1000, tbl_data, 0, -1, 32'h0000_0C01, o);
    compare_txn(o, 4'b1000, 3, OUT_RESP, 0, lane_words[3], 32'h0000_0C01);
    run_txn(4'b1001, tbl_data, 0, -1, 32'h0000_0C02, o);
    compare_txn(o, 4'b1001, 0, OUT_RESP, 0, lane_words[0], 32'h0000_0C02);

    // Random transactions against the model, starting from reset values
    apply_reset();
    model_last = NUM_REQ - 1;
    model_resp = '0;
    for (int n = 0; n < 150; n++) begin
      logic [NUM_REQ-1:0]        rq;
      logic [NUM_REQ*DATA_W-1:0] rd;
      logic [DATA_W-1:0]         rdat;
      int                        lat, fa, lane, e, oc;
      rq = NUM_REQ'($urandom_range(1, 2**NUM_REQ - 1));
      for (int i = 0; i < NUM_REQ; i++) rd[i*DATA_W +: DATA_W] = $urandom;
      lat  = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, TIMEOUT + 1));
      fa   = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, TIMEOUT - 1)) : -1;
      rdat = $urandom;
      lane = model_pick(rq, model_last);
      e    = model_end(lat, fa);
      oc   = model_outcome(lat, fa, e);
      run_txn(rq, rd, lat, fa, rdat, o);
      if (oc == OUT_RESP) model_resp = rdat;
      compare_txn(o, rq, lane, oc, e, rd[lane*DATA_W +: DATA_W], model_resp);
      if (oc != OUT_FLUSH) model_last = lane;
      if ($urandom_range(0, 3) == 0) idle_cycles(int'($urandom_range(1, 3)), model_resp);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
